// File: rtl/id_scoreboard_if.sv
// Issue/writeback/status bundle between the decode stage and its issue-control scoreboard.
// The master side is the decode/pipeline control; the slave side is the scoreboard.
interface id_scoreboard_if #(
    parameter int N_REG = 32
);
    localparam int RW = $clog2(N_REG);

    logic             flush;
    logic             ready_i;
    logic             issue_valid;
    logic [RW-1:0]    issue_rs1;
    logic [RW-1:0]    issue_rs2;
    logic             issue_use_rs1;
    logic             issue_use_rs2;
    logic             issue_we;
    logic [RW-1:0]    issue_rd;
    logic             issue_long;
    logic             issue_mul;
    logic             issue_div;
    logic             issue_hilo_rd;
    logic             wb_valid;
    logic [RW-1:0]    wb_addr;
    logic             stall_o;
    logic             issue_fire_o;
    logic [N_REG-1:0] pending_o;
    logic             mdu_busy_o;
    logic             mdu_done_o;

    modport master (
        output flush, ready_i, issue_valid, issue_rs1, issue_rs2,
               issue_use_rs1, issue_use_rs2, issue_we, issue_rd,
               issue_long, issue_mul, issue_div, issue_hilo_rd,
               wb_valid, wb_addr,
        input  stall_o, issue_fire_o, pending_o, mdu_busy_o, mdu_done_o
    );

    modport slave (
        input  flush, ready_i, issue_valid, issue_rs1, issue_rs2,
               issue_use_rs1, issue_use_rs2, issue_we, issue_rd,
               issue_long, issue_mul, issue_div, issue_hilo_rd,
               wb_valid, wb_addr,
        output stall_o, issue_fire_o, pending_o, mdu_busy_o, mdu_done_o
    );
endinterface

// File: rtl/id_scoreboard.sv
// Decode-stage issue scoreboard: tracks late-result destination registers and the
// multi-cycle multiply/divide unit, and stalls decode until operands are forwardable.
module id_scoreboard #(
    parameter int N_REG      = 32,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32,
    parameter int CW         = 6
) (
    input  logic            clk,
    input  logic            rst,
    id_scoreboard_if.slave  sb
);
    localparam int RW = $clog2(N_REG);

    logic [N_REG-1:0] pending_reg;
    logic [N_REG-1:0] pending_next;
    logic [N_REG-1:0] clr;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_next;
    logic             done_reg;
    logic             done_next;
    logic             raw1;
    logic             raw2;
    logic             waw;
    logic             struct_haz;
    logic             stall;
    logic             fire;

    // A writeback in the current cycle is bypassed by the forward path, so it resolves the hazard now.
    generate
        for (genvar gi = 0; gi < N_REG; gi++) begin : g_clr
            assign clr[gi] = sb.wb_valid && (sb.wb_addr == RW'(gi));
        end
    endgenerate

    always_comb begin
        raw1       = sb.issue_use_rs1 && (sb.issue_rs1 != '0)
                     && pending_reg[sb.issue_rs1] && !clr[sb.issue_rs1];
        raw2       = sb.issue_use_rs2 && (sb.issue_rs2 != '0)
                     && pending_reg[sb.issue_rs2] && !clr[sb.issue_rs2];
        waw        = sb.issue_we && (sb.issue_rd != '0)
                     && pending_reg[sb.issue_rd] && !clr[sb.issue_rd];
        struct_haz = (sb.issue_mul || sb.issue_div || sb.issue_hilo_rd) && (cnt_reg != '0);
        stall      = sb.issue_valid && !sb.flush && (raw1 || raw2 || waw || struct_haz);
        fire       = sb.issue_valid && sb.ready_i && !stall && !sb.flush;
    end

    // Clear first, then set, so a new late op wins over a same-cycle writeback of its rd.
    always_comb begin
        pending_next = pending_reg & ~clr;
        if (fire && sb.issue_we && sb.issue_long && (sb.issue_rd != '0)) begin
            pending_next[sb.issue_rd] = 1'b1;
        end
        if (sb.flush) begin
            pending_next = '0;
        end
        pending_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (sb.flush) begin
            cnt_next = '0;
        end else if (fire && sb.issue_div) begin
            cnt_next = CW'(DIV_CYCLES);
        end else if (fire && sb.issue_mul) begin
            cnt_next = CW'(MUL_CYCLES);
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CW'(1);
        end
        // A flush that lands on the final count must not report completion.
        done_next = (cnt_reg == CW'(1)) && (cnt_next == '0) && !sb.flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
            cnt_reg     <= '0;
            done_reg    <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
            done_reg    <= done_next;
        end
    end

    assign sb.stall_o      = stall;
    assign sb.issue_fire_o = fire;
    assign sb.pending_o    = pending_reg;
    assign sb.mdu_busy_o   = (cnt_reg != '0);
    assign sb.mdu_done_o   = done_reg;
endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: vector table plus hand-written divide, flush
// and reset sequences; registered results go through an expectation queue.
module tb_id_scoreboard;
    localparam int N_REG = 32;
    localparam int RW    = 5;

    logic clk;
    logic rst;

    id_scoreboard_if #(.N_REG(N_REG)) sbif ();

    id_scoreboard #(
        .N_REG(N_REG), .MUL_CYCLES(2), .DIV_CYCLES(32), .CW(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          valid, ready, flush;
        logic [RW-1:0] rs1;
        logic          use1;
        logic [RW-1:0] rs2;
        logic          use2;
        logic          we;
        logic [RW-1:0] rd;
        logic          lng, mul, div, hilo;
        logic          wbv;
        logic [RW-1:0] wba;
        logic          e_stall, e_fire;
        logic [31:0]   e_pend;
        logic          e_busy, e_done;
    } vec_t;

    typedef struct {
        logic [31:0] pend;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    function automatic vec_t mk(
        input logic v, input logic rdy, input logic fl,
        input logic [RW-1:0] r1, input logic u1, input logic [RW-1:0] r2, input logic u2,
        input logic w, input logic [RW-1:0] d, input logic lg, input logic ml,
        input logic dv, input logic hl, input logic wv, input logic [RW-1:0] wa,
        input logic es, input logic ef, input logic [31:0] ep, input logic eb, input logic ed);
        vec_t t;
        t.valid = v;  t.ready = rdy; t.flush = fl;
        t.rs1 = r1;   t.use1 = u1;   t.rs2 = r2;   t.use2 = u2;
        t.we = w;     t.rd = d;      t.lng = lg;   t.mul = ml;  t.div = dv; t.hilo = hl;
        t.wbv = wv;   t.wba = wa;
        t.e_stall = es; t.e_fire = ef; t.e_pend = ep; t.e_busy = eb; t.e_done = ed;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        sbif.issue_valid   = t.valid;
        sbif.ready_i       = t.ready;
        sbif.flush         = t.flush;
        sbif.issue_rs1     = t.rs1;
        sbif.issue_use_rs1 = t.use1;
        sbif.issue_rs2     = t.rs2;
        sbif.issue_use_rs2 = t.use2;
        sbif.issue_we      = t.we;
        sbif.issue_rd      = t.rd;
        sbif.issue_long    = t.lng;
        sbif.issue_mul     = t.mul;
        sbif.issue_div     = t.div;
        sbif.issue_hilo_rd = t.hilo;
        sbif.wb_valid      = t.wbv;
        sbif.wb_addr       = t.wba;
    endtask

    // One decode cycle: combinational outputs checked before the edge, state after it.
    task automatic step(input vec_t t, input string name);
        exp_t e;
        exp_t got;
        logic s_act, f_act;
        @(negedge clk);
        drive(t);
        #1;
        s_act = sbif.stall_o;
        f_act = sbif.issue_fire_o;
        chk({name, "_stall"}, 32'(s_act), 32'(t.e_stall));
        chk({name, "_fire"},  32'(f_act), 32'(t.e_fire));
        e.pend = t.e_pend; e.busy = t.e_busy; e.done = t.e_done;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_queue: got empty expected entry", name);
        end else begin
            got = q.pop_front();
            chk({name, "_pending"}, sbif.pending_o, got.pend);
            chk({name, "_busy"}, 32'(sbif.mdu_busy_o), 32'(got.busy));
            chk({name, "_done"}, 32'(sbif.mdu_done_o), 32'(got.done));
        end
        $display("step %0d %s: stall=%0b fire=%0b pending=%08h busy=%0b done=%0b",
                 step_no, name, s_act, f_act, sbif.pending_o, sbif.mdu_busy_o, sbif.mdu_done_o);
        step_no++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    vec_t tv[20];
    vec_t idle;
    vec_t mfhi;

    initial begin
        idle = mk(0,1,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0, 32'h0,0,0);
        // Load-use, raw on rs1 and rs2, writeback bypass
        tv[0]  = mk(1,1,0, 1,1,0,0, 1,5,1, 0,0,0, 0,0, 0,1, 32'h20,0,0);
        tv[1]  = mk(1,1,0, 5,1,0,0, 1,6,0, 0,0,0, 0,0, 1,0, 32'h20,0,0);
        tv[2]  = mk(1,1,0, 0,0,5,1, 1,6,0, 0,0,0, 0,0, 1,0, 32'h20,0,0);
        tv[3]  = mk(1,1,0, 5,1,0,0, 1,6,0, 0,0,0, 1,5, 0,1, 32'h00,0,0);
        // $zero is never pending
        tv[4]  = mk(1,1,0, 0,0,0,0, 1,0,1, 0,0,0, 0,0, 0,1, 32'h00,0,0);
        tv[5]  = mk(1,1,0, 0,1,0,0, 1,8,0, 0,0,0, 0,0, 0,1, 32'h00,0,0);
        // Same-cycle set and clear of r7, then WAW
        tv[6]  = mk(1,1,0, 0,0,0,0, 1,7,1, 0,0,0, 1,7, 0,1, 32'h80,0,0);
        tv[7]  = mk(1,1,0, 0,0,0,0, 1,7,1, 0,0,0, 0,0, 1,0, 32'h80,0,0);
        tv[8]  = mk(1,1,0, 0,0,0,0, 1,7,1, 0,0,0, 0,0, 1,0, 32'h80,0,0);
        tv[9]  = mk(1,1,0, 0,0,0,0, 1,7,1, 0,0,0, 1,7, 0,1, 32'h80,0,0);
        tv[10] = mk(0,1,0, 0,0,0,0, 0,0,0, 0,0,0, 1,7, 0,0, 32'h00,0,0);
        // Back-pressure, stray writeback, clears continue under ready_i=0
        tv[11] = mk(1,0,0, 0,0,0,0, 1,3,1, 0,0,0, 0,0, 0,0, 32'h00,0,0);
        tv[12] = mk(1,1,0, 0,0,0,0, 1,3,1, 0,0,0, 0,0, 0,1, 32'h08,0,0);
        tv[13] = mk(0,1,0, 0,0,0,0, 0,0,0, 0,0,0, 1,9, 0,0, 32'h08,0,0);
        tv[14] = mk(1,0,0, 0,0,0,0, 1,4,1, 0,0,0, 1,3, 0,0, 32'h00,0,0);
        // Multiply then mfhi structural stall
        tv[15] = mk(1,1,0, 2,1,3,1, 0,0,0, 1,0,0, 0,0, 0,1, 32'h00,1,0);
        tv[16] = mk(1,1,0, 0,0,0,0, 1,10,0, 0,0,1, 0,0, 1,0, 32'h00,1,0);
        tv[17] = mk(1,1,0, 0,0,0,0, 1,10,0, 0,0,1, 0,0, 1,0, 32'h00,0,1);
        tv[18] = mk(1,1,0, 0,0,0,0, 1,10,0, 0,0,1, 0,0, 0,1, 32'h00,0,0);
        // Flush masks issue entirely
        tv[19] = mk(1,1,1, 0,0,0,0, 1,12,1, 0,0,0, 0,0, 0,0, 32'h00,0,0);

        rst = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_pending", sbif.pending_o, 32'h0);
        chk("reset_busy", 32'(sbif.mdu_busy_o), 32'h0);
        chk("reset_done", 32'(sbif.mdu_done_o), 32'h0);
        chk("reset_stall", 32'(sbif.stall_o), 32'h0);
        chk("reset_fire", 32'(sbif.issue_fire_o), 32'h0);

        for (int i = 0; i < 20; i++) begin
            step(tv[i], $sformatf("vec%0d", i));
        end

        // Divide (mul also set: divide wins) and mfhi held behind it
        mfhi = mk(1,1,0, 0,0,0,0, 1,10,0, 0,0,1, 0,0, 1,0, 32'h0,1,0);
        step(mk(1,1,0, 2,1,3,1, 0,0,0, 1,1,0, 0,0, 0,1, 32'h0,1,0), "div_fire");
        for (int k = 1; k <= 32; k++) begin
            mfhi.e_busy = (k < 32);
            mfhi.e_done = (k == 32);
            step(mfhi, $sformatf("div_wait%0d", k));
        end
        mfhi.e_stall = 1'b0; mfhi.e_fire = 1'b1; mfhi.e_busy = 1'b0; mfhi.e_done = 1'b0;
        step(mfhi, "mfhi_fire");

        // Flush with r5/r10 pending and 10 divide cycles left
        step(mk(1,1,0, 0,0,0,0, 1,5,1, 0,0,0, 0,0, 0,1, 32'h020,0,0), "fl_lw5");
        step(mk(1,1,0, 0,0,0,0, 1,10,1, 0,0,0, 0,0, 0,1, 32'h420,0,0), "fl_lw10");
        step(mk(1,1,0, 0,0,0,0, 0,0,0, 0,1,0, 0,0, 0,1, 32'h420,1,0), "fl_div");
        for (int k = 0; k < 22; k++) begin
            step(mk(0,1,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0, 32'h420,1,0), $sformatf("fl_idle%0d", k));
        end
        step(mk(1,1,1, 0,0,0,0, 1,10,0, 0,0,1, 0,0, 0,0, 32'h0,0,0), "flush");
        for (int k = 0; k < 12; k++) begin
            step(idle, $sformatf("post_flush%0d", k));
        end

        // Asynchronous reset in the middle of a divide
        step(mk(1,1,0, 0,0,0,0, 1,5,1, 0,0,0, 0,0, 0,1, 32'h20,0,0), "rs_lw5");
        step(mk(1,1,0, 0,0,0,0, 0,0,0, 0,1,0, 0,0, 0,1, 32'h20,1,0), "rs_div");
        @(negedge clk);
        drive(idle);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pending", sbif.pending_o, 32'h0);
        chk("async_rst_busy", 32'(sbif.mdu_busy_o), 32'h0);
        chk("async_rst_done", 32'(sbif.mdu_done_o), 32'h0);
        $display("async reset: pending=%08h busy=%0b done=%0b",
                 sbif.pending_o, sbif.mdu_busy_o, sbif.mdu_done_o);
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
Issue-control scoreboard sitting beside inst_decode. It tracks destination registers of in-flight long-latency ops (loads, mfc0 and similar) and the multi-cycle multiply/divide unit. It produces the decode-stage stall that gates ready_o / pipe_id update. It sequences the regfile/forward datapath so that decode never issues an instruction whose operands are not yet forwardable.

Parameters:
N_REG, 32, number of architectural registers; reg address width RW = $clog2(N_REG)
MUL_CYCLES, 2, cycles the MDU is busy for a multiply (>=1)
DIV_CYCLES, 32, cycles the MDU is busy for a divide (>=1, > MUL_CYCLES)
CW, 6, MDU countdown width; must satisfy 2^CW > DIV_CYCLES

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  except_req.valid; kill all in-flight tracking
ready_i  in  1  downstream (ex) ready
issue_valid  in  1  decode holds a valid instruction (pipe_if.valid)
issue_rs1  in  RW  source 1 address
issue_rs2  in  RW  source 2 address
issue_use_rs1  in  1  instruction reads rs1
issue_use_rs2  in  1  instruction reads rs2
issue_we  in  1  instruction writes a GPR
issue_rd  in  RW  destination address
issue_long  in  1  result is produced late (load/mfc0); rd becomes pending
issue_mul  in  1  instruction starts a multiply
issue_div  in  1  instruction starts a divide
issue_hilo_rd  in  1  instruction reads HI/LO (mfhi/mflo)
wb_valid  in  1  late result written back this cycle
wb_addr  in  RW  writeback register
stall_o  out  1  decode must hold; ready_o = ready_i & ~stall_o
issue_fire_o  out  1  instruction accepted this cycle
pending_o  out  N_REG  per-register pending bitmap
mdu_busy_o  out  1  MDU countdown nonzero
mdu_done_o  out  1  one-cycle pulse when countdown reaches 0

Behaviour:
- Reset (async): pending_o = 0, MDU counter = 0, mdu_busy_o = 0, mdu_done_o = 0. stall_o and issue_fire_o are combinational; both are 0 while issue_valid = 0.
- clr[r] = wb_valid & (wb_addr == r). A writeback this cycle counts as resolved, because regs_forward bypasses it.
- Hazards (combinational, same cycle):
  - raw1 = use_rs1 & rs1 != 0 & pending[rs1] & ~clr[rs1]; raw2 is the same for rs2.
  - waw = we & rd != 0 & pending[rd] & ~clr[rd].
  - struct = (issue_mul | issue_div | issue_hilo_rd) & mdu_busy_o.
- stall_o = issue_valid & ~flush & (raw1 | raw2 | waw | struct).
- issue_fire_o = issue_valid & ready_i & ~stall_o & ~flush.
- Pending update, every posedge:
  - flush: pending = 0 (wrong-path writebacks are suppressed downstream).
  - Otherwise: clear bits with clr; then, if issue_fire_o & issue_we & issue_long & rd != 0, set pending[rd]. Set wins over a same-cycle clear of the same register.
  - Register 0 is never pending.
  - wb to a non-pending register is ignored.
- MDU countdown, every posedge:
  - flush: counter = 0, no done pulse.
  - issue_fire_o & issue_div: counter = DIV_CYCLES. Otherwise issue_fire_o & issue_mul: counter = MUL_CYCLES. issue_mul and issue_div both set: divide takes priority.
  - Otherwise, if counter != 0: counter - 1.
  - mdu_done_o is registered; it is 1 in the cycle after the counter transitions 1 -> 0.
  - mdu_busy_o = (counter != 0).
- Latency: a divide issued at cycle t gives mdu_busy_o = 1 for cycles t+1 .. t+DIV_CYCLES, and mdu_done_o at t+DIV_CYCLES+1. mfhi held from t+1 fires at t+DIV_CYCLES+1.
- ready_i = 0 freezes the decode instruction: no fire and no set. Clears and the countdown continue.
- Flush mid-divide: busy drops the next cycle, and no done pulse is produced.
- Reset mid-operation: everything returns to reset values immediately.

Test Plan:
- Load-use: fire lw with rd=5 and issue_long; next cycle add uses rs1=5 with no wb -> stall_o=1, pending_o[5]=1. Assert wb_valid with wb_addr=5 -> stall_o=0 that same cycle, issue_fire_o=1, pending_o[5]=0 next cycle.
- $zero: lw with rd=0 and issue_long -> pending_o stays 0; next instruction using rs1=0 -> stall_o=0.
- Same-cycle set/clear: wb_addr=7 together with firing lw rd=7 -> pending_o[7]=1 afterwards. A following WAW lw with rd=7 stalls until the next wb to 7.
- Divide: fire div at t=0 with DIV_CYCLES=32 -> mdu_busy_o=1 for t=1..32, mdu_done_o=1 only at t=33. mfhi presented from t=1 -> stall_o=1 through t=32, issue_fire_o at t=33.
- Flush: pending_o=0x00000420 with 10 cycles left on a divide; assert flush -> next cycle pending_o=0, mdu_busy_o=0, and no mdu_done_o pulse ever.
- Back-pressure: ready_i=0 with a hazard-free lw rd=3 -> issue_fire_o=0, pending_o[3]=0. Raise ready_i -> fires, and pending_o[3]=1 next cycle.
